// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one L2-side cacheline port between the L1 I-cache
// (reads only) and the L1 D-cache (reads and writebacks). One line transaction
// is in flight at a time. Requests are levels; completions are one-cycle pulses.
module l1_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int RR_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache miss port
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache miss / writeback port
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // L2 side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              grant_d
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [LINE_W-1:0]   line_q;
  logic                i_resp_q;
  logic                d_resp_q;
  logic                grant_d_q;
  logic                last_d_q;

  logic                d_req;
  logic                any_req;
  logic                win_d;

  // Arbitration: a lone requester wins; on a tie either D always wins or the
  // requester that did not own the previous transaction wins.
  always_comb begin
    d_req   = d_read | d_write;
    any_req = d_req | i_read;
    win_d   = 1'b0;
    if (d_req && i_read)
      win_d = (RR_MODE != 0) ? ~last_d_q : 1'b1;
    else
      win_d = d_req;
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      line_q      <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      grant_d_q   <= 1'b0;
      last_d_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_d_q <= win_d;
            last_d_q  <= win_d;
            if (win_d) begin
              // A write wins over a read if the D-cache raises both.
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              mem_write_q <= d_write;
              mem_read_q  <= ~d_write;
            end else begin
              mem_addr_q  <= i_addr;
              mem_write_q <= 1'b0;
              mem_read_q  <= 1'b1;
            end
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (mem_read_q) line_q <= mem_rdata;
            if (grant_d_q) d_resp_q <= 1'b1;
            else           i_resp_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign i_rdata   = line_q;
  assign d_rdata   = line_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;
  assign grant_d   = grant_d_q;

endmodule
